// File: rtl/ninjin_ddr_port_if.sv
// Burst request, buffer-side and memory-side signals of the ninjin DDR port.
// The slave modport is the port itself; master is the environment (buffer + memory).
interface ninjin_ddr_port_if #(
    parameter int WORDSIZE = 32,
    parameter int LSB      = 2,
    parameter int LWIDTH   = 12,
    parameter int BWIDTH   = 32
);
    logic                    ddr_req;
    logic                    ddr_mode;
    logic [WORDSIZE+LSB-1:0] ddr_base;
    logic [LWIDTH-1:0]       ddr_len;
    logic                    ddr_busy;
    logic                    ddr_we;
    logic [WORDSIZE-1:0]     ddr_waddr;
    logic [BWIDTH-1:0]       ddr_wdata;
    logic [WORDSIZE-1:0]     ddr_raddr;
    logic [BWIDTH-1:0]       ddr_rdata;
    logic [WORDSIZE+LSB-1:0] m_addr;
    logic                    m_rd;
    logic                    m_wr;
    logic [BWIDTH-1:0]       m_wdata;
    logic                    m_ready;
    logic                    m_rvalid;
    logic [BWIDTH-1:0]       m_rdata;

    modport slave (
        input  ddr_req, ddr_mode, ddr_base, ddr_len, ddr_rdata, m_ready, m_rvalid, m_rdata,
        output ddr_busy, ddr_we, ddr_waddr, ddr_wdata, ddr_raddr, m_addr, m_rd, m_wr, m_wdata
    );

    modport master (
        output ddr_req, ddr_mode, ddr_base, ddr_len, ddr_rdata, m_ready, m_rvalid, m_rdata,
        input  ddr_busy, ddr_we, ddr_waddr, ddr_wdata, ddr_raddr, m_addr, m_rd, m_wr, m_wdata
    );
endinterface

// File: rtl/ninjin_ddr_port.sv
// DDR-side burst responder: READ fills the buffer from memory, WRITE drains the
// buffer to memory through a small FIFO. All outputs come straight from registers.
module ninjin_ddr_port #(
    parameter int WORDSIZE        = 32,
    parameter int LSB             = 2,
    parameter int LWIDTH          = 12,
    parameter int BWIDTH          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WFIFO_DEPTH     = 4
) (
    input logic             clk,
    input logic             rst,
    ninjin_ddr_port_if.slave bus
);
    localparam int AW = WORDSIZE + LSB;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int CW = $clog2(WFIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       base_q, base_d;
    logic [LWIDTH-1:0]   len_q, len_d;
    logic [LWIDTH-1:0]   issue_q, issue_d, recv_q, recv_d;
    logic [LWIDTH-1:0]   rdc_q, rdc_d, wrc_q, wrc_d;
    logic [OW-1:0]       outst_q, outst_d;
    logic                rdv_q, rdv_d;  // buffer read address presented this cycle
    logic                cap_q, cap_d;  // buffer read data valid this cycle
    logic [PW-1:0]       wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BWIDTH-1:0]   fifo_q [WFIFO_DEPTH];

    logic                busy_q, busy_d, we_q, we_d, mrd_q, mrd_d, mwr_q, mwr_d;
    logic [WORDSIZE-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [BWIDTH-1:0]   wdata_q, wdata_d, mwdata_q, mwdata_d;
    logic [AW-1:0]       maddr_q, maddr_d;

    logic                accept, ret, push, pop;
    logic [LWIDTH-1:0]   issue_n, wrc_n;
    logic [CW-1:0]       cnt_n;
    logic [PW-1:0]       rp_n;
    logic [WORDSIZE-1:0] base_word;

    assign base_word = base_q[AW-1:LSB];

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issue_d  = issue_q;
        recv_d   = recv_q;
        rdc_d    = rdc_q;
        wrc_d    = wrc_q;
        outst_d  = outst_q;
        rdv_d    = 1'b0;
        cap_d    = 1'b0;
        wp_d     = wp_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        we_d     = 1'b0;
        waddr_d  = '0;
        wdata_d  = '0;
        raddr_d  = '0;
        maddr_d  = '0;
        mrd_d    = 1'b0;
        mwr_d    = 1'b0;
        mwdata_d = '0;
        accept   = 1'b0;
        ret      = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        issue_n  = issue_q;
        wrc_n    = wrc_q;
        cnt_n    = cnt_q;
        rp_n     = rp_q;

        case (state_q)
            IDLE: begin
                if (bus.ddr_req) begin
                    base_d  = bus.ddr_base;
                    len_d   = bus.ddr_len;
                    busy_d  = 1'b1;
                    issue_d = '0;
                    recv_d  = '0;
                    rdc_d   = '0;
                    wrc_d   = '0;
                    outst_d = '0;
                    wp_d    = '0;
                    rp_d    = '0;
                    cnt_d   = '0;
                    if (bus.ddr_len == '0) state_d = DONE;
                    else                   state_d = bus.ddr_mode ? WRITE : READ;
                end
            end
            READ: begin
                accept  = mrd_q & bus.m_ready;
                // A return with nothing outstanding is stale traffic from before a reset.
                ret     = bus.m_rvalid && (outst_q != '0);
                issue_n = issue_q + LWIDTH'(accept);
                issue_d = issue_n;
                outst_d = outst_q + OW'(accept) - OW'(ret);
                if (ret) begin
                    we_d    = 1'b1;
                    waddr_d = base_word + WORDSIZE'(recv_q);
                    wdata_d = bus.m_rdata;
                    recv_d  = recv_q + LWIDTH'(1);
                end
                if (mrd_q && !bus.m_ready) begin
                    mrd_d   = 1'b1;
                    maddr_d = maddr_q;
                end else if (issue_n < len_q && outst_d < OW'(MAX_OUTSTANDING)) begin
                    mrd_d   = 1'b1;
                    maddr_d = base_q + (AW'(issue_n) << LSB);
                end
                if (recv_d == len_q) state_d = DONE;
            end
            WRITE: begin
                pop   = mwr_q & bus.m_ready;
                push  = cap_q;
                wrc_n = wrc_q + LWIDTH'(pop);
                wrc_d = wrc_n;
                rp_n  = rp_q + PW'(pop);
                rp_d  = rp_n;
                if (push) wp_d = wp_q + PW'(1);
                cnt_n = cnt_q + CW'(push) - CW'(pop);
                cnt_d = cnt_n;
                // Head is presented from the register stage; bypass when the FIFO was empty.
                if (cnt_n != '0) begin
                    mwr_d    = 1'b1;
                    mwdata_d = ((cnt_q - CW'(pop)) == '0) ? bus.ddr_rdata : fifo_q[rp_n];
                    maddr_d  = base_q + (AW'(wrc_n) << LSB);
                end
                cap_d = rdv_q;
                if (rdc_q < len_q && (int'(cnt_n) + int'(rdv_q)) < WFIFO_DEPTH) begin
                    rdv_d   = 1'b1;
                    raddr_d = base_word + WORDSIZE'(rdc_q);
                    rdc_d   = rdc_q + LWIDTH'(1);
                end
                if (wrc_n == len_q) state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issue_q  <= '0;
            recv_q   <= '0;
            rdc_q    <= '0;
            wrc_q    <= '0;
            outst_q  <= '0;
            rdv_q    <= 1'b0;
            cap_q    <= 1'b0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            raddr_q  <= '0;
            maddr_q  <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            issue_q  <= issue_d;
            recv_q   <= recv_d;
            rdc_q    <= rdc_d;
            wrc_q    <= wrc_d;
            outst_q  <= outst_d;
            rdv_q    <= rdv_d;
            cap_q    <= cap_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            raddr_q  <= raddr_d;
            maddr_q  <= maddr_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            mwdata_q <= mwdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wp_q] <= bus.ddr_rdata;
    end

    assign bus.ddr_busy  = busy_q;
    assign bus.ddr_we    = we_q;
    assign bus.ddr_waddr = waddr_q;
    assign bus.ddr_wdata = wdata_q;
    assign bus.ddr_raddr = raddr_q;
    assign bus.m_addr    = maddr_q;
    assign bus.m_rd      = mrd_q;
    assign bus.m_wr      = mwr_q;
    assign bus.m_wdata   = mwdata_q;
endmodule

// File: doc/ninjin_ddr_port.md
Name: ninjin_ddr_port

Overview:
DDR-side responder for the ninjin DDR buffer's burst request interface. Accepts one ddr_req burst (read-into-buffer or write-from-buffer) and executes it word by word against a simple pipelined memory port. Read mode fills the buffer through ddr_we/ddr_waddr/ddr_wdata. Write mode drains the buffer through ddr_raddr/ddr_rdata.

Parameters:
WORDSIZE, 32, buffer word-address width
LSB, 2, log2 bytes per BWIDTH word
LWIDTH, 12, burst length width
BWIDTH, 32, data width
MAX_OUTSTANDING, 4, maximum accepted-but-unreturned memory reads
WFIFO_DEPTH, 4, write-data FIFO entries (power of 2, ≥3)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ddr_req  in  1  burst request, sampled only in IDLE
ddr_mode  in  1  0=READ (memory→buffer), 1=WRITE (buffer→memory)
ddr_base  in  WORDSIZE+LSB  burst byte base address
ddr_len  in  LWIDTH  burst length in BWIDTH words
ddr_busy  out  1  high from accept until return to IDLE
ddr_we  out  1  buffer write strobe
ddr_waddr  out  WORDSIZE  buffer write word address
ddr_wdata  out  BWIDTH  buffer write data
ddr_raddr  out  WORDSIZE  buffer read word address
ddr_rdata  in  BWIDTH  buffer read data, valid 1 cycle after ddr_raddr
m_addr  out  WORDSIZE+LSB  memory byte address
m_rd  out  1  memory read request
m_wr  out  1  memory write request
m_wdata  out  BWIDTH  memory write data
m_ready  in  1  request accepted when (m_rd|m_wr)&m_ready
m_rvalid  in  1  read data valid, in request order
m_rdata  in  BWIDTH  read data

Behaviour:
- All outputs registered. Reset value of every output is 0. Reset clears all counters and the FIFO and returns to IDLE, also mid-burst. In-flight m_rvalid after reset is ignored.
- States: IDLE, READ, WRITE, DONE.
- IDLE: if ddr_req=1, latch base, len, and mode. Set ddr_busy=1 on the next edge and go to READ or WRITE per ddr_mode. If len=0, go straight to DONE.
- base_word = ddr_base >> LSB. Word i has buffer address base_word+i and memory address ddr_base + (i<<LSB). Both wrap modulo their width.
- READ:
  - Issue m_rd with incrementing m_addr while issue_cnt<len and outstanding<MAX_OUTSTANDING.
  - Hold m_rd/m_addr stable until m_ready. outstanding = issued − returned.
  - On m_rvalid: next cycle ddr_we=1, ddr_waddr=base_word+recv_cnt, ddr_wdata=m_rdata. recv_cnt increments.
  - Accept and return in the same cycle: outstanding unchanged.
  - recv_cnt==len → DONE. m_rvalid outside READ is ignored.
- WRITE:
  - Present ddr_raddr=base_word+rd_cnt when FIFO count + inflight buffer reads < WFIFO_DEPTH. rd_cnt<len.
  - Capture ddr_rdata into the FIFO the following cycle.
  - FIFO non-empty: drive m_wr=1, m_wdata=head, m_addr=ddr_base+(wr_cnt<<LSB). Hold until m_ready, then pop and increment wr_cnt.
  - Sustains 1 word/cycle with m_ready=1.
  - wr_cnt==len → DONE. ddr_raddr returns to 0 when no read is issued.
- DONE: one cycle, ddr_busy=0 on the next edge, return to IDLE. A new request is accepted no earlier than the cycle after ddr_busy falls.
- ddr_req while busy is ignored and not queued.
- m_rd and m_wr are never both high. ddr_we is never high in WRITE state.

Test Plan:
- READ, base 'ha000, len 4, m_ready=1, rvalid latency 2 → 4 m_rd at 'ha000..'ha00c. ddr_we pulses with waddr 'h2800..'h2803 and matching m_rdata. busy drops 1 cycle after the last ddr_we.
- READ len 16 with rvalid delayed 10 cycles → exactly 4 m_rd accepted before the first return. All 16 words written in order.
- WRITE, base 'ha000, len 8, buffer word k = k+5, m_ready toggling 1/0 → 8 m_wr at 'ha000..'ha01c with m_wdata 5..12. No data lost or duplicated.
- len=0 in either mode → no m_rd/m_wr/ddr_we. busy high 1–2 cycles then low.
- ddr_req pulsed mid-burst → ignored, burst completes unchanged. rst asserted after 3 words → all outputs 0 next cycle. Subsequent burst runs correctly with stale m_rvalid ignored.
